// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches over a req/ack handshake, latches the instruction
// and forms the next PC from pc+4 or the datapath branch/jump target.
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            PCScr,
    input  logic [XLEN-1:0] pc_target,
    input  logic            stall,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign_err
);

    typedef enum logic [1:0] {IDLE, REQ, VALID, HALT} state_t;

    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    state_t state, state_nxt;
    logic   idle_done;
    logic   commit;
    logic   misalign;

    assign commit    = (state == VALID) && !stall;
    assign misalign  = PCScr && (pc_target[1:0] != 2'b00);
    assign pc_plus4  = pc + XLEN'(4);
    assign imem_addr = pc;
    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // IDLE is held for one full cycle after reset is released before the first request
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (idle_done) state_nxt = REQ;
            REQ:     if (imem_ack)  state_nxt = VALID;
            VALID:   if (commit)    state_nxt = misalign ? HALT : REQ;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (state == REQ);
        instr_valid = (state == VALID);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            instr        <= NOP;
            misalign_err <= 1'b0;
            idle_done    <= 1'b0;
        end else begin
            idle_done <= (state == IDLE);
            if (state == REQ && imem_ack)
                instr <= imem_rdata;
            // PC is left alone on a misaligned target so the faulting PC stays visible
            if (commit) begin
                if (!PCScr)        pc           <= pc_plus4;
                else if (!misalign) pc          <= pc_target;
                else               misalign_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a scoreboard of expected (pc, instr) pairs pushed at ack
// time and popped when the DUT presents a valid instruction.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        PCScr;
    logic [31:0] pc_target;
    logic        stall;
    logic [31:0] instr;
    logic        instr_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign_err;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .PCScr(PCScr), .pc_target(pc_target), .stall(stall),
        .instr(instr), .instr_valid(instr_valid),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .pc(pc), .pc_plus4(pc_plus4), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } sb_t;

    sb_t         sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mpc;
    logic [31:0] last_ins;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Serve one request at mpc with the given number of wait states, then check VALID
    task automatic fetch(input logic [31:0] data, input int waits);
        sb_t e;
        int  t;
        for (int i = 0; i < waits; i++) begin
            chk("req_wait", 32'(imem_req), 32'd1);
            chk("addr_wait", imem_addr, mpc);
            cyc();
        end
        chk("req", 32'(imem_req), 32'd1);
        chk("addr", imem_addr, mpc);
        imem_ack   = 1'b1;
        imem_rdata = data;
        sb_q.push_back('{pc: mpc, ins: data});
        cyc();
        imem_ack   = 1'b0;
        imem_rdata = 32'hx;
        t = 0;
        while (!instr_valid && t < 8) begin
            cyc();
            t++;
        end
        if (!instr_valid) begin
            chk("valid_timeout", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("instr", instr, e.ins);
            chk("pc", pc, e.pc);
            chk("pc_plus4", pc_plus4, e.pc + 32'd4);
            chk("opcode", 32'(opcode), 32'(e.ins[6:0]));
            chk("funct3", 32'(funct3), 32'(e.ins[14:12]));
            chk("funct7", 32'(funct7), 32'(e.ins[31:25]));
            chk("req_after_ack", 32'(imem_req), 32'd0);
            last_ins = e.ins;
        end
    endtask

    // Commit from VALID with the given next-PC selection; model updates mpc
    task automatic commit(input logic scr, input logic [31:0] tgt);
        logic mis;
        mis       = scr && (tgt[1:0] != 2'b00);
        stall     = 1'b0;
        PCScr     = scr;
        pc_target = tgt;
        cyc();
        PCScr     = 1'b0;
        pc_target = 32'h0;
        if (!scr)      mpc = mpc + 32'd4;
        else if (!mis) mpc = tgt;
        chk("valid_after_commit", 32'(instr_valid), 32'd0);
        chk("pc_after_commit", pc, mpc);
        chk("misalign_err", 32'(misalign_err), 32'(mis));
        chk("req_after_commit", 32'(imem_req), 32'(!mis));
        if (!mis) chk("addr_after_commit", imem_addr, mpc);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        mpc = 32'h0;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h13);
        chk("rst_opcode", 32'(opcode), 32'h13);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("idle_req", 32'(imem_req), 32'd0);
        cyc();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        PCScr      = 1'b0;
        pc_target  = 32'h0;
        stall      = 1'b0;
        mpc        = 32'h0;
        last_ins   = 32'h13;
        @(negedge clk);
        do_reset();

        // zero-wait sequential fetch
        fetch(32'h0050_0093, 0);
        commit(1'b0, 32'h0);
        fetch(32'h00A0_0113, 0);
        commit(1'b0, 32'h0);

        // three wait states at pc=8
        fetch(32'h0000_0213, 3);

        // stall with a misaligned target and stray ack offered: both must be ignored
        for (int i = 0; i < 5; i++) begin
            stall      = 1'b1;
            PCScr      = 1'b1;
            pc_target  = 32'h42;
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            cyc();
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_pc", pc, 32'h8);
            chk("stall_instr", instr, last_ins);
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_misalign", 32'(misalign_err), 32'd0);
        end
        imem_ack   = 1'b0;
        commit(1'b0, 32'h0);
        chk("stall_release_pc", pc, 32'hC);

        // branch taken
        fetch(32'h0020_C463, 1);
        commit(1'b1, 32'h40);
        chk("branch_addr", imem_addr, 32'h40);
        fetch(32'h40A5_8533, 0);

        // wrap of pc + 4
        commit(1'b1, 32'hFFFF_FFFC);
        fetch(32'h0000_0013, 2);
        chk("wrap_plus4", pc_plus4, 32'h0);
        commit(1'b0, 32'h0);
        chk("wrap_pc", pc, 32'h0);

        // misaligned target -> HALT, nothing further
        fetch(32'h0000_006F, 0);
        commit(1'b1, 32'h42);
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1;
            cyc();
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_valid", 32'(instr_valid), 32'd0);
            chk("halt_pc", pc, 32'h0);
            chk("halt_misalign", 32'(misalign_err), 32'd1);
        end
        imem_ack = 1'b0;

        // recover via reset, then reset during a REQ wait with a late ack
        do_reset();
        cyc();
        chk("wait_req", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        cyc();
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0BAD;
        cyc();
        imem_ack = 1'b0;
        chk("late_ack_instr", instr, 32'h13);
        chk("late_ack_pc", pc, 32'h0);
        chk("late_ack_req", 32'(imem_req), 32'd0);
        chk("late_ack_valid", 32'(instr_valid), 32'd0);
        chk("late_ack_misalign", 32'(misalign_err), 32'd0);
        cyc();
        mpc = 32'h0;
        fetch(32'h0010_0093, 0);
        commit(1'b0, 32'h0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
